// File: rtl/grade_pkg.sv
// -----------------------------------------------------------------------------
// grade_pkg
// Shared types and widths for the ap_ctrl_hs initiator that drives the `grade`
// HLS core.
//   state_e    : driver FSM states
//   operands_t : one operand set {p, b, c, m, cs}
// -----------------------------------------------------------------------------
package grade_pkg;

  localparam int GRADE_W = 8;
  localparam int ARG_W   = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_e;

  typedef struct packed {
    logic [ARG_W-1:0] p;
    logic [ARG_W-1:0] b;
    logic [ARG_W-1:0] c;
    logic [ARG_W-1:0] m;
    logic [ARG_W-1:0] cs;
  } operands_t;

endpackage

// File: rtl/grade_lat_timer.sv
// -----------------------------------------------------------------------------
// grade_lat_timer
// Saturating latency counter with a timeout compare.
//   clk, rst_i  : clock, synchronous active-high reset
//   clr_i       : load the counter with 1 (first ap_start cycle counts as 1)
//   en_i        : increment, holding at all-ones
//   count_o     : current count
//   expired_o   : count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module grade_lat_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LAT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [LAT_W-1:0] count_o,
  output logic             expired_o
);

  localparam logic [LAT_W:0] TIMEOUT_EXT = (LAT_W+1)'(TIMEOUT_CYCLES);

  logic [LAT_W-1:0] count_q;
  logic [LAT_W-1:0] count_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = LAT_W'(1);
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + LAT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = ({1'b0, count_q} >= TIMEOUT_EXT);

endmodule

// File: rtl/grade_ap_driver.sv
// -----------------------------------------------------------------------------
// grade_ap_driver
// Initiator for the ap_ctrl_hs handshake of the `grade` core. Accepts one
// operand set on the req channel, pulses ap_start with arguments held, waits
// for ap_done (or a timeout) and returns the grade on the res channel.
//   ap_clk, ap_rst                 : clock, synchronous active-high reset
//   req_valid/req_ready, req_*     : operand request channel
//   res_valid/res_ready, res_*     : result channel (grade, timeout, latency)
//   txn_count                      : completed transactions, wraps
//   ap_start, p/b/c/m/cs           : to core
//   ap_done/ap_idle/ap_ready       : from core; ap_return valid with ap_done
// -----------------------------------------------------------------------------
module grade_ap_driver
  import grade_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LAT_W          = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ARG_W-1:0]   req_p,
  input  logic [ARG_W-1:0]   req_b,
  input  logic [ARG_W-1:0]   req_c,
  input  logic [ARG_W-1:0]   req_m,
  input  logic [ARG_W-1:0]   req_cs,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [GRADE_W-1:0] res_grade,
  output logic               res_timeout,
  output logic [LAT_W-1:0]   res_latency,
  output logic [15:0]        txn_count,
  output logic               ap_start,
  input  logic               ap_done,
  input  logic               ap_idle,
  input  logic               ap_ready,
  output logic [ARG_W-1:0]   p,
  output logic [ARG_W-1:0]   b,
  output logic [ARG_W-1:0]   c,
  output logic [ARG_W-1:0]   m,
  output logic [ARG_W-1:0]   cs,
  input  logic [GRADE_W-1:0] ap_return
);

  state_e             state_q;
  operands_t          ops_q;
  logic               ap_start_q;
  logic               res_valid_q;
  logic [GRADE_W-1:0] res_grade_q;
  logic               res_timeout_q;
  logic [LAT_W-1:0]   res_latency_q;
  logic [15:0]        txn_count_q;

  logic [LAT_W-1:0]   lat_count;
  logic               lat_expired;

  // The core may still be finishing a previous call; ap_start is issued
  // regardless of ap_idle, so it is intentionally unused.
  logic unused_ap_idle;
  assign unused_ap_idle = ap_idle;

  wire busy     = (state_q == RUN) || (state_q == WAIT_DONE);
  wire accept   = (state_q == IDLE) && req_valid;
  // ap_done in the expiry cycle is a normal completion, so it masks the abort.
  wire finish   = busy && ap_done;
  wire abort    = busy && !ap_done && lat_expired;

  grade_lat_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .LAT_W          (LAT_W)
  ) u_lat_timer (
    .clk       (ap_clk),
    .rst_i     (ap_rst),
    .clr_i     (accept),
    .en_i      (busy),
    .count_o   (lat_count),
    .expired_o (lat_expired)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= IDLE;
      ops_q         <= '0;
      ap_start_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_grade_q   <= '0;
      res_timeout_q <= 1'b0;
      res_latency_q <= '0;
      txn_count_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            ops_q      <= '{p: req_p, b: req_b, c: req_c, m: req_m, cs: req_cs};
            ap_start_q <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN, WAIT_DONE: begin
          if (finish || abort) begin
            ap_start_q    <= 1'b0;
            res_valid_q   <= 1'b1;
            res_grade_q   <= finish ? ap_return : '0;
            res_timeout_q <= abort;
            res_latency_q <= finish ? lat_count : LAT_W'(TIMEOUT_CYCLES);
            state_q       <= RESP;
          end else if ((state_q == RUN) && ap_ready) begin
            // Core has latched the arguments; keep them but release ap_start.
            ap_start_q <= 1'b0;
            state_q    <= WAIT_DONE;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            txn_count_q <= txn_count_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign ap_start    = ap_start_q;
  assign res_valid   = res_valid_q;
  assign res_grade   = res_grade_q;
  assign res_timeout = res_timeout_q;
  assign res_latency = res_latency_q;
  assign txn_count   = txn_count_q;
  assign p           = ops_q.p;
  assign b           = ops_q.b;
  assign c           = ops_q.c;
  assign m           = ops_q.m;
  assign cs          = ops_q.cs;

endmodule

// File: doc/grade_ap_driver.md
Name: grade_ap_driver

Overview:
- Initiator side of the ap_ctrl_hs handshake used by the `grade` HLS core (ports ap_start/ap_done/ap_idle/ap_ready, args p/b/c/m/cs, 8-bit ap_return).
- Accepts one operand set over a valid/ready request channel and drives ap_start with the arguments held stable.
- Waits for ap_done, captures ap_return, and presents the grade plus status over a valid/ready result channel.
- Sits between the test/host interconnect and the `grade` wrapper; one transaction outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles from ap_start rise to ap_done before abort; must be >=2
- LAT_W, 16, width of latency counter and result latency field; saturates at all-ones

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- req_valid  in  1  operand set valid
- req_ready  out  1  driver can accept operands
- req_p, req_b, req_c, req_m, req_cs  in  32 each  operands
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_grade  out  8  captured ap_return
- res_timeout  out  1  transaction aborted by timeout; res_grade=0
- res_latency  out  LAT_W  cycles from ap_start assert to ap_done (inclusive)
- txn_count  out  16  completed transactions (including timeouts), wraps
- ap_start  out  1  to core
- ap_done, ap_idle, ap_ready  in  1 each  from core
- p, b, c, m, cs  out  32 each  arguments to core
- ap_return  in  8  core result, valid only in the ap_done cycle

Behaviour:
- Clock is ap_clk; reset is ap_rst, synchronous and active-high.
- Reset values:
  - state=IDLE
  - req_ready=1 (combinational from IDLE)
  - ap_start=0
  - res_valid=0, res_grade=0, res_timeout=0, res_latency=0
  - txn_count=0
  - p/b/c/m/cs=0
- States: IDLE, RUN, WAIT_DONE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register operands into p..cs, clear latency counter to 1 and enter RUN.
  - ap_start rises the cycle after acceptance.
  - ap_idle is not required to be 1.
- RUN:
  - ap_start=1 and arguments held constant.
  - Latency counter increments each cycle.
  - ap_ready=1: drop ap_start next cycle.
  - Same cycle as ap_ready, ap_done=1: capture ap_return and go to RESP. Otherwise go to WAIT_DONE.
  - ap_done=1 without ap_ready: capture and go to RESP; ap_start drops.
- WAIT_DONE:
  - ap_start=0, arguments still held.
  - On ap_done: res_grade<=ap_return, res_latency<=counter, res_timeout<=0, go to RESP.
- Timeout (RUN or WAIT_DONE):
  - When counter reaches TIMEOUT_CYCLES with no ap_done: ap_start<=0, res_grade<=0, res_timeout<=1, res_latency<=TIMEOUT_CYCLES, go to RESP.
  - ap_done in the same cycle as timeout expiry wins, i.e. it is a normal completion.
- RESP:
  - res_valid=1.
  - Outputs stable until res_ready.
  - On res_valid&res_ready: txn_count+=1 and go to IDLE.
  - req_ready stays 0 in RESP, so there is no overlap.
- Stray ap_done/ap_ready in IDLE or RESP are ignored and change nothing.
- Latency counter saturates at 2^LAT_W-1.
- ap_rst mid-transaction:
  - Next edge forces the IDLE/reset values; ap_start drops immediately.
  - The in-flight result is discarded and txn_count is cleared.
- Throughput with a combinational core (ap_done=ap_ready=1 in the first ap_start cycle), with no idle cycle inserted by the consumer:
  - accept → RUN → RESP → IDLE.
  - 3-cycle minimum per transaction when res_ready=1.

Decomposition:
- Shared package grade_pkg:
  - state enum (IDLE, RUN, WAIT_DONE, RESP)
  - GRADE_W=8, ARG_W=32
  - operand struct {p,b,c,m,cs}
- One natural sub-module: grade_lat_timer. Saturating LAT_W counter with clear/enable and a timeout-compare output.

Test Plan:
- Combinational core model (done=ready=1 on the first start cycle), operands p=85,b=90,c=70,m=88,cs=95, returns 8'h41:
  - res_grade=8'h41, res_latency=1, res_timeout=0
  - ap_start high exactly 1 cycle
  - txn_count=1
- Pipelined model with ap_ready after 2 cycles and ap_done after 7:
  - ap_start high 2 cycles
  - p..cs stable until done
  - res_latency=7
- Model never asserts done, TIMEOUT_CYCLES=16: res_timeout=1, res_grade=0, res_latency=16, ap_start=0 after abort.
- Back-pressure:
  - res_ready held 0 for 10 cycles: res_valid and res_grade stable, req_ready=0.
  - Then handshake: next request accepted the following cycle.
- ap_rst asserted in WAIT_DONE:
  - Next cycle ap_start=0, res_valid=0, txn_count=0.
  - A late ap_done afterwards produces no result.
- Stray ap_done pulse in IDLE with ap_return=8'hFF: no res_valid, res_grade unchanged.
